// File: rtl/gsm_pkg.sv
// Shared constants and FSM state type for the gsm ingress traffic generator.
package gsm_pkg;

  localparam logic [7:0]  FLAG_HEAD = 8'hEF;
  localparam logic [7:0]  FLAG_DAT  = 8'hCD;
  localparam logic [63:0] DAT_PAD   = 64'hDDDD;

  localparam int unsigned OFF_FLAG = 0;
  localparam int unsigned OFF_CNT  = 8;
  localparam int unsigned OFF_SRC  = 16;
  localparam int unsigned OFF_LEN  = 24;
  localparam int unsigned OFF_MASK = 32;
  localparam int unsigned OFF_PAD  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } gsm_state_t;

endpackage

// File: rtl/gsm_traffic_gen_port.sv
// One ingress port: packet FSM, counters, destination mask and registered cell outputs.
// GSM_TGEN_LFSR_EN randomises per-packet length and gap with a 16-bit Galois LFSR.
module gsm_traffic_gen_port
  import gsm_pkg::*;
#(
  parameter int unsigned DWIDTH      = 256,
  parameter int unsigned GAP_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SWITCH_SIZE = 16,
  parameter int unsigned PORT_ID     = 0
) (
  input  logic              clk_80M,
  input  logic              clr_80M,
  input  logic              enable,
  input  logic              hold,
  input  logic [7:0]        pkt_len,
  input  logic [GAP_W-1:0]  gap,
  input  logic              dest_rotate,
  output logic              valid,
  output logic              header,
  output logic [DWIDTH-1:0] data,
  output logic [CNT_W-1:0]  pkt_sent,
  output logic              busy
);

  localparam logic [7:0]  SRC_ID   = 8'(PORT_ID);
  localparam logic [31:0] MASK_RST = (32'd1 << PORT_ID) | (32'd1 << ((PORT_ID + 1) % SWITCH_SIZE));

  gsm_state_t       state, state_n;
  logic [7:0]       len_q, len_n, rem_q, rem_n, pkt_cnt_q, pkt_cnt_n;
  logic [GAP_W-1:0] gap_q, gap_n, gcnt_q, gcnt_n;
  logic [31:0]      mask_q, mask_n;
  logic [CNT_W-1:0] sent_n;
  logic             valid_n, header_n, latch, eop;
  logic [DWIDTH-1:0] data_n, body;
  logic [7:0]       len_min1, lat_len;
  logic [GAP_W-1:0] lat_gap;
  logic [DWIDTH+63:0] body_wide;

  assign len_min1 = (pkt_len == 8'd0) ? 8'd1 : pkt_len;

`ifdef GSM_TGEN_LFSR_EN
  logic [15:0] lfsr_q;

  assign lat_len = 8'd1 + (lfsr_q[7:0] % len_min1);
  assign lat_gap = lfsr_q[GAP_W+7:8] & gap;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk_80M or posedge clr_80M) begin
    if (clr_80M)    lfsr_q <= 16'hACE1 ^ 16'(PORT_ID);
    else if (latch) lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
`else
  assign lat_len = len_min1;
  assign lat_gap = gap;
`endif

  // Pad sits above bit 63; building it wide keeps DWIDTH == 64 legal
  assign body_wide = {DWIDTH'(DAT_PAD), mask_q, len_q, SRC_ID, pkt_cnt_q, 8'h00};
  assign body      = body_wide[DWIDTH-1:0];

  always_ff @(posedge clk_80M or posedge clr_80M) begin
    if (clr_80M) begin
      state     <= IDLE;
      len_q     <= 8'd1;
      rem_q     <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      pkt_cnt_q <= '0;
      mask_q    <= MASK_RST;
      pkt_sent  <= '0;
      valid     <= 1'b0;
      header    <= 1'b0;
      data      <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      rem_q     <= rem_n;
      gap_q     <= gap_n;
      gcnt_q    <= gcnt_n;
      pkt_cnt_q <= pkt_cnt_n;
      mask_q    <= mask_n;
      pkt_sent  <= sent_n;
      valid     <= valid_n;
      header    <= header_n;
      data      <= data_n;
      busy      <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    rem_n     = rem_q;
    gap_n     = gap_q;
    gcnt_n    = gcnt_q;
    pkt_cnt_n = pkt_cnt_q;
    mask_n    = mask_q;
    sent_n    = pkt_sent;
    valid_n   = 1'b0;
    header_n  = 1'b0;
    data_n    = data;
    latch     = 1'b0;
    eop       = 1'b0;
    if (!hold) begin
      unique case (state)
        IDLE: if (enable) begin
          latch   = 1'b1;
          state_n = HEAD;
        end
        HEAD: begin
          valid_n  = 1'b1;
          header_n = 1'b1;
          data_n   = body | DWIDTH'(FLAG_HEAD);
          if (len_q == 8'd1) eop = 1'b1;
          else begin
            rem_n   = len_q - 8'd1;
            state_n = DATA;
          end
        end
        DATA: begin
          valid_n = 1'b1;
          data_n  = body | DWIDTH'(FLAG_DAT);
          rem_n   = rem_q - 8'd1;
          if (rem_q == 8'd1) eop = 1'b1;
        end
        GAP: begin
          if (gcnt_q == GAP_W'(1)) begin
            if (enable) begin
              latch   = 1'b1;
              state_n = HEAD;
            end else state_n = IDLE;
          end else gcnt_n = gcnt_q - GAP_W'(1);
        end
      endcase
      if (eop) begin
        pkt_cnt_n = pkt_cnt_q + 8'd1;
        sent_n    = pkt_sent + CNT_W'(1);
        if (dest_rotate) mask_n = {mask_q[30:0], mask_q[31]};
        if (gap_q != '0) begin
          gcnt_n  = gap_q;
          state_n = GAP;
        end else if (enable) begin
          latch   = 1'b1;
          state_n = HEAD;
        end else state_n = IDLE;
      end
      if (latch) begin
        len_n = lat_len;
        gap_n = lat_gap;
      end
    end
  end

endmodule

// File: rtl/gsm_traffic_gen.sv
// Ingress traffic generator for gsm_sys: SWITCH_SIZE independent port generators, buses packed.
// Optional GSM_TGEN_LFSR_EN randomises per-packet length/gap inside each port.
module gsm_traffic_gen #(
  parameter int unsigned DWIDTH      = 256,
  parameter int unsigned MWIDTH      = 4,
  parameter int unsigned GSIZE       = 4,
  parameter int unsigned SWITCH_SIZE = MWIDTH * GSIZE,
  parameter int unsigned GAP_W       = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk_80M,
  input  logic                          clr_80M,
  input  logic [SWITCH_SIZE-1:0]        i_enable,
  input  logic [SWITCH_SIZE-1:0]        i_hold,
  input  logic [7:0]                    i_pkt_len,
  input  logic [GAP_W-1:0]              i_gap,
  input  logic                          i_dest_rotate,
  output logic [SWITCH_SIZE-1:0]        o_ingress_valid,
  output logic [SWITCH_SIZE-1:0]        o_ingress_header,
  output logic [SWITCH_SIZE*DWIDTH-1:0] o_ingress_data,
  output logic [SWITCH_SIZE*CNT_W-1:0]  o_pkt_sent,
  output logic [SWITCH_SIZE-1:0]        o_busy
);

  for (genvar p = 0; p < SWITCH_SIZE; p++) begin : g_port
    gsm_traffic_gen_port #(
      .DWIDTH      (DWIDTH),
      .GAP_W       (GAP_W),
      .CNT_W       (CNT_W),
      .SWITCH_SIZE (SWITCH_SIZE),
      .PORT_ID     (p)
    ) u_port (
      .clk_80M     (clk_80M),
      .clr_80M     (clr_80M),
      .enable      (i_enable[p]),
      .hold        (i_hold[p]),
      .pkt_len     (i_pkt_len),
      .gap         (i_gap),
      .dest_rotate (i_dest_rotate),
      .valid       (o_ingress_valid[p]),
      .header      (o_ingress_header[p]),
      .data        (o_ingress_data[p*DWIDTH +: DWIDTH]),
      .pkt_sent    (o_pkt_sent[p*CNT_W +: CNT_W]),
      .busy        (o_busy[p])
    );
  end

endmodule

// File: tb/tb_gsm_traffic_gen.sv
// Directed self-checking bench for gsm_traffic_gen (default build, 16 ports x 256 bits).
module tb_gsm_traffic_gen;
  import gsm_pkg::*;

  localparam int unsigned DW = 256;
  localparam int unsigned SS = 16;
  localparam int unsigned GW = 4;
  localparam int unsigned CW = 16;

  logic              clk_80M = 1'b0;
  logic              clr_80M = 1'b1;
  logic [SS-1:0]     i_enable = '1;
  logic [SS-1:0]     i_hold = '0;
  logic [7:0]        i_pkt_len = 8'd2;
  logic [GW-1:0]     i_gap = '0;
  logic              i_dest_rotate = 1'b0;
  logic [SS-1:0]     o_ingress_valid, o_ingress_header, o_busy;
  logic [SS*DW-1:0]  o_ingress_data;
  logic [SS*CW-1:0]  o_pkt_sent;

  int checks = 0;
  int errors = 0;

  always #6 clk_80M = ~clk_80M;

  gsm_traffic_gen #(.DWIDTH(DW), .MWIDTH(4), .GSIZE(4), .SWITCH_SIZE(SS), .GAP_W(GW), .CNT_W(CW)) dut (
    .clk_80M          (clk_80M),
    .clr_80M          (clr_80M),
    .i_enable         (i_enable),
    .i_hold           (i_hold),
    .i_pkt_len        (i_pkt_len),
    .i_gap            (i_gap),
    .i_dest_rotate    (i_dest_rotate),
    .o_ingress_valid  (o_ingress_valid),
    .o_ingress_header (o_ingress_header),
    .o_ingress_data   (o_ingress_data),
    .o_pkt_sent       (o_pkt_sent),
    .o_busy           (o_busy)
  );

  function automatic logic [DW-1:0] cell_of(input int unsigned p);
    return o_ingress_data[p*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] sent_of(input int unsigned p);
    return o_pkt_sent[p*CW +: CW];
  endfunction

  function automatic logic [31:0] rst_mask(input int unsigned p);
    return (32'd1 << p) | (32'd1 << ((p + 1) % SS));
  endfunction

  function automatic logic [DW-1:0] mk_cell(input logic [7:0] flag, input logic [7:0] cnt,
                                            input logic [7:0] src, input logic [7:0] len,
                                            input logic [31:0] mask);
    logic [DW-1:0] c;
    c          = '0;
    c[7:0]     = flag;
    c[15:8]    = cnt;
    c[23:16]   = src;
    c[31:24]   = len;
    c[63:32]   = mask;
    c[DW-1:64] = (DW-64)'(64'hDDDD);
    return c;
  endfunction

  // Ends on the negedge where reset is released; first cell shows two negedges later
  task automatic restart(input logic [SS-1:0] en, input logic [7:0] len, input logic [GW-1:0] gap,
                         input logic rot);
    clr_80M = 1'b1;
    i_enable = en; i_hold = '0; i_pkt_len = len; i_gap = gap; i_dest_rotate = rot;
    repeat (2) @(negedge clk_80M);
    clr_80M = 1'b0;
  endtask

  task automatic test_reset();
    clr_80M = 1'b1;
    repeat (2) @(negedge clk_80M);
    checks++; if (o_ingress_valid !== '0) begin errors++; $display("FAIL reset_valid: got %h want 0", o_ingress_valid); end
    checks++; if (o_ingress_header !== '0) begin errors++; $display("FAIL reset_header: got %h want 0", o_ingress_header); end
    checks++; if (o_busy !== '0) begin errors++; $display("FAIL reset_busy: got %h want 0", o_busy); end
    checks++; if (o_ingress_data !== '0) begin errors++; $display("FAIL reset_data: nonzero data bus"); end
    checks++; if (o_pkt_sent !== '0) begin errors++; $display("FAIL reset_sent: got %h want 0", o_pkt_sent); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] c;
    restart('1, 8'd2, '0, 1'b0);
    @(negedge clk_80M);
    checks++; if (o_ingress_valid !== '0) begin errors++; $display("FAIL basic_lat_valid: got %h want 0", o_ingress_valid); end
    checks++; if (o_busy !== '1) begin errors++; $display("FAIL basic_busy: got %h want ffff", o_busy); end
    @(negedge clk_80M);
    checks++; if (o_ingress_valid !== '1) begin errors++; $display("FAIL basic_hdr_valid: got %h want ffff", o_ingress_valid); end
    checks++; if (o_ingress_header !== '1) begin errors++; $display("FAIL basic_hdr_flag: got %h want ffff", o_ingress_header); end
    c = cell_of(0);
    checks++; if (c !== mk_cell(FLAG_HEAD, 8'd0, 8'd0, 8'd2, 32'h3)) begin errors++; $display("FAIL basic_hdr_p0: got %h want %h", c[63:0], mk_cell(FLAG_HEAD, 8'd0, 8'd0, 8'd2, 32'h3)); end
    c = cell_of(15);
    checks++; if (c[63:32] !== 32'h8001) begin errors++; $display("FAIL basic_mask_p15: got %h want 00008001", c[63:32]); end
    checks++; if (c[23:16] !== 8'd15) begin errors++; $display("FAIL basic_src_p15: got %h want 0f", c[23:16]); end
    @(negedge clk_80M);
    checks++; if (o_ingress_header !== '0) begin errors++; $display("FAIL basic_dat_flag: got %h want 0", o_ingress_header); end
    c = cell_of(0);
    checks++; if (c !== mk_cell(FLAG_DAT, 8'd0, 8'd0, 8'd2, 32'h3)) begin errors++; $display("FAIL basic_dat_p0: got %h want %h", c[63:0], mk_cell(FLAG_DAT, 8'd0, 8'd0, 8'd2, 32'h3)); end
    checks++; if (sent_of(0) !== 16'd1) begin errors++; $display("FAIL basic_sent: got %0d want 1", sent_of(0)); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_80M);
      checks++; if (o_ingress_valid !== '1) begin errors++; $display("FAIL basic_nobubble[%0d]: got %h want ffff", k, o_ingress_valid); end
      checks++; if (o_ingress_header !== ((k % 2 == 0) ? 16'hffff : 16'h0000)) begin errors++; $display("FAIL basic_alt[%0d]: got %h", k, o_ingress_header); end
      if (k == 0) begin
        c = cell_of(0);
        checks++; if (c[15:0] !== 16'h01EF) begin errors++; $display("FAIL basic_hdr2: got %h want 01ef", c[15:0]); end
      end
    end
  endtask

  task automatic test_gap();
    logic [DW-1:0] c;
    restart('1, 8'd0, 4'd3, 1'b0);
    @(negedge clk_80M);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_80M);
      checks++; if (o_ingress_valid !== ((k % 4 == 0) ? 16'hffff : 16'h0000)) begin errors++; $display("FAIL gap_valid[%0d]: got %h", k, o_ingress_valid); end
      checks++; if (sent_of(0) !== 16'(k / 4 + 1)) begin errors++; $display("FAIL gap_sent[%0d]: got %0d want %0d", k, sent_of(0), k / 4 + 1); end
      if (k % 4 == 0) begin
        c = cell_of(0);
        checks++; if (c !== mk_cell(FLAG_HEAD, 8'(k / 4), 8'd0, 8'd1, 32'h3)) begin errors++; $display("FAIL gap_cell[%0d]: got %h", k, c[63:0]); end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] c;
    restart('1, 8'd4, '0, 1'b0);
    repeat (2) @(negedge clk_80M);
    checks++; if (o_ingress_header[5] !== 1'b1) begin errors++; $display("FAIL drop_hdr: got %b want 1", o_ingress_header[5]); end
    i_enable[5] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_80M);
      c = cell_of(5);
      checks++; if (o_ingress_valid[5] !== 1'b1 || o_ingress_header[5] !== 1'b0) begin errors++; $display("FAIL drop_data[%0d]: valid %b header %b want 1 0", k, o_ingress_valid[5], o_ingress_header[5]); end
      checks++; if (c !== mk_cell(FLAG_DAT, 8'd0, 8'd5, 8'd4, rst_mask(5))) begin errors++; $display("FAIL drop_cell[%0d]: got %h", k, c[63:0]); end
      if (k == 0) i_pkt_len = 8'd2;
    end
    checks++; if (sent_of(5) !== 16'd1) begin errors++; $display("FAIL drop_sent: got %0d want 1", sent_of(5)); end
    @(negedge clk_80M);
    checks++; if (o_busy[5] !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", o_busy[5]); end
    c = cell_of(4);
    checks++; if (o_ingress_header[4] !== 1'b1 || c !== mk_cell(FLAG_HEAD, 8'd1, 8'd4, 8'd2, rst_mask(4))) begin errors++; $display("FAIL drop_relatch_p4: got %h", c[63:0]); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (o_ingress_valid[5] !== 1'b0) begin errors++; $display("FAIL drop_quiet[%0d]: got 1 want 0", k); end
      @(negedge clk_80M);
    end
  endtask

  task automatic test_rotate();
    logic [DW-1:0] c;
    logic [31:0] m [3];
    m = '{32'hC, 32'h18, 32'h30};
    restart(16'h0004, 8'd1, '0, 1'b1);
    @(negedge clk_80M);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_80M);
      c = cell_of(2);
      checks++; if (o_ingress_valid !== 16'h0004) begin errors++; $display("FAIL rot_valid[%0d]: got %h want 0004", k, o_ingress_valid); end
      checks++; if (c !== mk_cell(FLAG_HEAD, 8'(k), 8'd2, 8'd1, m[k])) begin errors++; $display("FAIL rot_mask[%0d]: got %h want %h", k, c[63:32], m[k]); end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] c;
    restart(16'h0001, 8'd1, '0, 1'b0);
    @(negedge clk_80M);
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk_80M);
      c = cell_of(0);
      checks++; if (c[15:0] !== {8'(k), 8'hEF}) begin errors++; $display("FAIL wrap_cnt[%0d]: got %h want %h", k, c[15:0], {8'(k), 8'hEF}); end
      if (k == 255) begin
        checks++; if (sent_of(0) !== 16'd256) begin errors++; $display("FAIL wrap_sent256: got %0d want 256", sent_of(0)); end
      end
    end
  endtask

  task automatic test_hold_clr();
    logic [DW-1:0] c;
    restart('1, 8'd4, '0, 1'b0);
    repeat (3) @(negedge clk_80M);
    i_hold[3] = 1'b1;
    @(negedge clk_80M);
    checks++; if (o_ingress_valid[3] !== 1'b0 || o_ingress_valid[2] !== 1'b1) begin errors++; $display("FAIL hold_c1: valid3 %b valid2 %b want 0 1", o_ingress_valid[3], o_ingress_valid[2]); end
    @(negedge clk_80M);
    checks++; if (o_ingress_valid[3] !== 1'b0 || o_busy[3] !== 1'b1) begin errors++; $display("FAIL hold_c2: valid3 %b busy3 %b want 0 1", o_ingress_valid[3], o_busy[3]); end
    i_hold[3] = 1'b0;
    @(negedge clk_80M);
    c = cell_of(3);
    checks++; if (o_ingress_valid[3] !== 1'b1 || c !== mk_cell(FLAG_DAT, 8'd0, 8'd3, 8'd4, rst_mask(3))) begin errors++; $display("FAIL hold_resume: valid %b cell %h", o_ingress_valid[3], c[63:0]); end
    checks++; if (o_ingress_header[2] !== 1'b1) begin errors++; $display("FAIL hold_p2_free: got %b want 1", o_ingress_header[2]); end
    repeat (2) @(negedge clk_80M);
    c = cell_of(3);
    checks++; if (o_ingress_header[3] !== 1'b1 || c !== mk_cell(FLAG_HEAD, 8'd1, 8'd3, 8'd4, rst_mask(3))) begin errors++; $display("FAIL hold_next_hdr: header %b cell %h", o_ingress_header[3], c[63:0]); end
    @(negedge clk_80M);
    #2 clr_80M = 1'b1;
    #1;
    checks++; if (o_ingress_valid !== '0 || o_ingress_header !== '0 || o_busy !== '0) begin errors++; $display("FAIL clr_async_ctl: valid %h header %h busy %h want 0", o_ingress_valid, o_ingress_header, o_busy); end
    checks++; if (o_ingress_data !== '0 || o_pkt_sent !== '0) begin errors++; $display("FAIL clr_async_data: data or counters nonzero"); end
    @(negedge clk_80M);
    clr_80M = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_enable_drop();
    test_rotate();
    test_wrap();
    test_hold_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsm_traffic_gen.md
Name: gsm_traffic_gen

Overview:
- Synthesizable, parametrised ingress traffic generator for gsm_sys. Drives SWITCH_SIZE ingress ports with header and data cells in the gsm cell format.
- Adds per-port packet length, inter-packet gap, destination-mask rotation, per-port hold and packet counters.
- Sits between the clk_80M domain reset/clock logic and the gsm_sys i_ingress_* inputs. Used for on-chip bring-up and regression.

Parameters:
- DWIDTH, 256, cell width in bits; must be ≥ 64.
- MWIDTH, 4, multicast width (output ports per group).
- GSIZE, 4, gsm_unit groups.
- SWITCH_SIZE, MWIDTH*GSIZE, ports driven; must be ≤ 32.
- GAP_W, 4, width of the inter-packet gap field.
- CNT_W, 16, width of the per-port sent-packet counter.

Ports:
- clk_80M  in  1  sole clock.
- clr_80M  in  1  asynchronous active-high reset.
- i_enable  in  SWITCH_SIZE  per-port run enable (level).
- i_hold  in  SWITCH_SIZE  per-port freeze; the current cell is not emitted this cycle.
- i_pkt_len  in  8  cells per packet, header included; 0 is treated as 1.
- i_gap  in  GAP_W  idle cycles between packets.
- i_dest_rotate  in  1  when 1, rotate each port's destination mask left by 1 after every packet.
- o_ingress_valid  out  SWITCH_SIZE  cell valid.
- o_ingress_header  out  SWITCH_SIZE  1 = header cell.
- o_ingress_data  out  SWITCH_SIZE*DWIDTH  cells; port p occupies [(p+1)*DWIDTH-1 : p*DWIDTH].
- o_pkt_sent  out  SWITCH_SIZE*CNT_W  per-port count of completed packets; wraps.
- o_busy  out  SWITCH_SIZE  port is not in IDLE.

Behaviour:
- Reset: all outputs are 0, every FSM is in IDLE, pkt_cnt = 0. Each destination mask resets to ((1<<p)|(1<<((p+1)%SWITCH_SIZE))), zero-extended to 32 bits.
- All outputs are registered. A cell appears one cycle after the FSM decides to emit it.
- Cell format, LSB first:
  - [7:0] = 8'hEF for a header cell, 8'hCD for a data cell.
  - [15:8] = pkt_cnt.
  - [23:16] = source ID p.
  - [31:24] = packet length L.
  - [63:32] = destination mask.
  - [DWIDTH-1:64] = 64'hDDDD zero-extended.
- Per-port FSM states: IDLE, HEAD, DATA, GAP.
  - IDLE: when i_enable[p]=1, latch L = max(i_pkt_len, 1) and G = i_gap, then go to HEAD.
  - HEAD: emit the header cell. If L=1, end the packet; otherwise go to DATA with the remaining count at L-1.
  - DATA: emit a data cell and decrement. At zero, end the packet.
  - End of packet: pkt_cnt += 1 (8-bit wrap 255→0), o_pkt_sent += 1 (wrap), and rotate the mask if i_dest_rotate is set. Next state:
    - GAP if G > 0.
    - HEAD if G = 0 and i_enable[p] = 1; relatch L and G.
    - IDLE otherwise.
  - GAP: valid=0 and count down G. At expiry go to HEAD (relatch L and G) if enabled, else IDLE.
- L and G are latched per packet. Changes to i_pkt_len or i_gap mid-packet do not take effect until the next packet.
- Deasserting i_enable mid-packet: the packet completes, then the port goes to IDLE. No truncated packets are ever emitted.
- i_hold[p]=1: o_ingress_valid[p]=0 on the next cycle, and the FSM, counters and mask are frozen. On release, the same cell is emitted.
- i_hold has priority over state transitions, including IDLE→HEAD and GAP expiry.
- Ports run independently. With identical inputs and simultaneous enable, ports run in lockstep.
- Asynchronous clr_80M mid-packet: outputs clear immediately and the partial packet is abandoned.

Optional Feature:
- Macro GSM_TGEN_LFSR_EN.
- Defined: each port has a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seeded with 16'hACE1 ^ p.
  - At each packet latch: L = 1 + (lfsr[7:0] % max(i_pkt_len, 1)) and G = lfsr[GAP_W+7:8] & i_gap.
  - The LFSR advances once per latch.
- Undefined: fixed L and G as above, and no LFSR logic is present.

Decomposition:
- Package gsm_pkg holds:
  - FLAG_HEAD = 8'hEF and FLAG_DAT = 8'hCD.
  - DAT_PAD = 64'hDDDD.
  - Field offsets: 0, 8, 16, 24, 32, 64.
  - FSM state typedef (IDLE, HEAD, DATA, GAP).
- Sub-module gsm_traffic_gen_port holds one FSM, its counters, mask and LFSR. The top level instantiates SWITCH_SIZE copies in a generate loop and packs the buses.

Test Plan:
1. Release reset, i_enable=all 1s, i_pkt_len=2, i_gap=0.
   - Port 0 emits alternating header/data cells with no bubbles.
   - First cell [15:0] = 16'h00EF, [23:16] = 0, [63:32] = 32'h3.
   - Second cell [15:0] = 16'h00CD.
   - Port 15 mask = 32'h8001.
2. Set i_pkt_len=0, i_gap=3.
   - Every cell is a header, each followed by 3 invalid cycles.
   - o_pkt_sent increments by 1 every 4 cycles.
3. Set i_pkt_len=4 and drop i_enable[5] one cycle after its header.
   - Port 5 still emits 3 data cells, then o_busy[5]=0.
   - No further cells from port 5.
4. Set i_dest_rotate=1 and run 3 packets on port 2.
   - Masks are 32'hC, 32'h18, 32'h30.
5. Run 256 packets.
   - pkt_cnt wraps; header [15:8] returns to 8'h00.
   - o_pkt_sent = 256.
6. Pulse i_hold[3] for 2 cycles mid-packet, then assert clr_80M mid-packet.
   - Two valid=0 cycles, then the identical cell resumes.
   - On clr_80M, all outputs go to 0 asynchronously.
